// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter: NUM_SRC masters share one sink; define ARB_PKT_LIMIT_EN for a MAX_PKT_LEN beat cap with pkt_trunc.
// Latency: input beat reaches m_axis 1 cycle after acceptance (2 from tvalid when idle); one arbitration cycle between packets.
// Backpressure: only the granted source sees tready, and only while the output register is empty or draining.
module axis_rr_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 64,
  localparam int GRANT_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                            axis_aclk,
  input  logic                            axis_aresetn,
  input  logic                            enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_SRC-1:0]              s_axis_tvalid,
  input  logic [NUM_SRC-1:0]              s_axis_tlast,
  output logic [NUM_SRC-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_axis_tstrb,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [GRANT_W-1:0]              grant_id,
  output logic                            busy,
  output logic                            pkt_done
`ifdef ARB_PKT_LIMIT_EN
  ,
  output logic                            pkt_trunc
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [STRB_W-1:0]     strb;
    logic                  last;
  } beat_t;

  state_t             state, state_nxt;
  beat_t              out_q, in_beat;
  logic [GRANT_W-1:0] last_grant, winner;
  logic               win_vld, out_rdy, accept, in_last, eop, limit_hit;
  logic [15:0]        beat_cnt;

  assign out_rdy   = !m_axis_tvalid || m_axis_tready;
  assign in_last   = s_axis_tlast[grant_id];
  assign accept    = (state == XFER) && s_axis_tvalid[grant_id] && out_rdy;
  assign limit_hit = (beat_cnt == 16'(MAX_PKT_LEN - 1));

`ifdef ARB_PKT_LIMIT_EN
  assign eop = in_last || limit_hit;
`else
  logic unused_limit;
  assign unused_limit = limit_hit;
  assign eop          = in_last;
`endif

  assign in_beat = {s_axis_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH],
                    s_axis_tstrb[int'(grant_id)*STRB_W +: STRB_W],
                    eop};

  // Scan offsets from far to near so the nearest valid source after last_grant wins.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = last_grant;
    win_vld = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (s_axis_tvalid[idx]) begin
        winner  = GRANT_W'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    case (state)
      IDLE: if (enable && win_vld) state_nxt = XFER;
      XFER: begin
        s_axis_tready[grant_id] = out_rdy;
        if (accept && eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) state <= IDLE;
    else               state <= state_nxt;
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      out_q         <= '0;
      m_axis_tvalid <= 1'b0;
      grant_id      <= '0;
      last_grant    <= GRANT_W'(NUM_SRC - 1);
      beat_cnt      <= '0;
      pkt_done      <= 1'b0;
`ifdef ARB_PKT_LIMIT_EN
      pkt_trunc     <= 1'b0;
`endif
    end else begin
      pkt_done <= accept && eop;
`ifdef ARB_PKT_LIMIT_EN
      pkt_trunc <= accept && limit_hit && !in_last;
`endif
      if (state == IDLE && enable && win_vld) grant_id <= winner;
      if (accept) begin
        out_q         <= in_beat;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept && eop) last_grant <= grant_id;
      if (state == IDLE || (accept && eop)) beat_cnt <= '0;
      else if (accept && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
    end
  end

  assign m_axis_tdata = out_q.dat;
  assign m_axis_tstrb = out_q.strb;
  assign m_axis_tlast = out_q.last;
  assign busy         = (state == XFER);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: packet-level round-robin model feeds an expected-beat queue checked by a monitor.
module tb_axis_rr_arbiter;
  localparam int NSRC = 3;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int LIM  = 4;
  localparam int GW   = 2;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [SW-1:0] strb;
    logic          last_in;
    logic          last_out;
    logic          first;
  } sbeat_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [SW-1:0] strb;
    logic          last;
  } obeat_t;

  logic              clk;
  logic              axis_aresetn, enable, m_tready;
  logic [NSRC*DW-1:0] s_tdata;
  logic [NSRC*SW-1:0] s_tstrb;
  logic [NSRC-1:0]   s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [SW-1:0]     m_tstrb;
  logic              m_tvalid, m_tlast;
  logic [GW-1:0]     grant_id;
  logic              busy, pkt_done;
`ifdef ARB_PKT_LIMIT_EN
  logic              pkt_trunc;
`endif

  logic          tv[NSRC];
  logic          tl[NSRC];
  logic [DW-1:0] td[NSRC];
  logic [SW-1:0] ts[NSRC];

  sbeat_t src_q[NSRC][$];
  int     chunk_q[NSRC][$];
  obeat_t expq[$];

  int mdl_last, exp_pkts, exp_trunc;
  int n_tests, n_fail;
  int pkt_cnt, trunc_cnt, beats_out, cyc, last_beat_cyc;
  int sink_mode, pat_i;
  bit mon_en, bubble_en;
  logic [7:0] pat;

  axis_rr_arbiter #(.NUM_SRC(NSRC), .DATA_WIDTH(DW), .MAX_PKT_LEN(LIM)) dut (
    .axis_aclk    (clk),
    .axis_aresetn (axis_aresetn),
    .enable       (enable),
    .s_axis_tdata (s_tdata),
    .s_axis_tstrb (s_tstrb),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tstrb (m_tstrb),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .grant_id     (grant_id),
    .busy         (busy),
    .pkt_done     (pkt_done)
`ifdef ARB_PKT_LIMIT_EN
    ,
    .pkt_trunc    (pkt_trunc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int s = 0; s < NSRC; s++) begin
      s_tdata[s*DW +: DW] = td[s];
      s_tstrb[s*SW +: SW] = ts[s];
      s_tvalid[s]         = tv[s];
      s_tlast[s]          = tl[s];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One source packet; chunk boundaries are where the sink must see tlast.
  task automatic gen_pkt(input int s, input int len, input logic [27:0] base, input bit rnd);
    int cl;
    cl = 0;
    for (int k = 1; k <= len; k++) begin
      sbeat_t b;
      b.dat     = rnd ? {4'(s), 28'($urandom)} : {4'(s), base + 28'(k - 1)};
      b.strb    = rnd ? 4'($urandom) : 4'hF;
      b.last_in = (k == len);
`ifdef ARB_PKT_LIMIT_EN
      b.first    = ((k - 1) % LIM) == 0;
      b.last_out = (k == len) || (k % LIM == 0);
      if (k % LIM == 0 && k != len) exp_trunc++;
`else
      b.first    = (k == 1);
      b.last_out = (k == len);
`endif
      src_q[s].push_back(b);
      cl++;
      if (b.last_out) begin
        chunk_q[s].push_back(cl);
        cl = 0;
      end
    end
  endtask

  // Packet-level rotation: next source after the previous winner that still has a chunk pending.
  task automatic schedule();
    int pos[NSRC];
    int s, len;
    for (int i = 0; i < NSRC; i++) pos[i] = 0;
    while (1) begin
      s = -1;
      for (int k = 1; k <= NSRC; k++) begin
        int c;
        c = (mdl_last + k) % NSRC;
        if (s < 0 && chunk_q[c].size() > 0) s = c;
      end
      if (s < 0) break;
      len = chunk_q[s].pop_front();
      for (int j = 0; j < len; j++) begin
        sbeat_t b;
        b = src_q[s][pos[s] + j];
        expq.push_back('{dat: b.dat, strb: b.strb, last: b.last_out});
      end
      pos[s] += len;
      mdl_last = s;
      exp_pkts++;
    end
  endtask

  // Bubbles only inside a chunk, so every pending source is valid whenever the arbiter is idle.
  task automatic drive_src(input int s);
    int   wd;
    logic acc, bub;
    sbeat_t b;
    wd = 0;
    while (src_q[s].size() > 0 && wd < 3000) begin
      b     = src_q[s][0];
      bub   = bubble_en && !b.first && ($urandom_range(0, 3) == 0);
      tv[s] = !bub;
      td[s] = b.dat;
      ts[s] = b.strb;
      tl[s] = b.last_in;
      @(negedge clk);
      acc = tv[s] && s_tready[s];
      @(posedge clk);
      #1;
      if (acc) void'(src_q[s].pop_front());
      wd++;
    end
    check("driver_beats_left", 64'(src_q[s].size()), 64'(0));
    tv[s] = 1'b0;
  endtask

  task automatic run_phase(input int smode, input int drop_after, input bit chk_lat, input int exp_span);
    int t0, w;
    pkt_cnt   = 0;
    trunc_cnt = 0;
    beats_out = 0;
    exp_pkts  = 0;
    sink_mode = smode;
    enable    = 1'b1;
    schedule();
    @(posedge clk);
    #1;
    t0     = cyc;
    mon_en = 1'b1;
    fork
      drive_src(0);
      drive_src(1);
      drive_src(2);
      begin
        if (drop_after > 0) begin
          w = 0;
          while (beats_out < drop_after && w < 500) begin
            @(posedge clk);
            w++;
          end
          #1;
          enable = 1'b0;
        end
      end
      begin
        if (chk_lat) begin
          int n;
          n = -1;
          for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_tvalid) begin
              n = i;
              break;
            end
          end
          check("first_beat_latency", 64'(n), 64'(2));
          check("grant_id_first", 64'(grant_id), 64'(0));
          check("busy_in_xfer", 64'(busy), 64'(1));
        end
      end
    join
    w = 0;
    while (expq.size() > 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    check("beats_outstanding", 64'(expq.size()), 64'(0));
    sink_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check("pkt_done_count", 64'(pkt_cnt), 64'(exp_pkts));
`ifdef ARB_PKT_LIMIT_EN
    check("pkt_trunc_count", 64'(trunc_cnt), 64'(exp_trunc));
`endif
    exp_trunc = 0;
    if (exp_span >= 0) check("last_beat_cycle", 64'(last_beat_cyc - t0 - 1), 64'(exp_span));
    expq.delete();
    for (int s = 0; s < NSRC; s++) begin
      src_q[s].delete();
      chunk_q[s].delete();
    end
    enable = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
    check({tag, "_m_tdata"}, 64'({m_tdata, m_tstrb, m_tlast}), 64'(0));
    check({tag, "_s_tready"}, 64'(s_tready), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_grant_id"}, 64'(grant_id), 64'(0));
    check({tag, "_pkt_done"}, 64'(pkt_done), 64'(0));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       m_tready = 1'($urandom_range(0, 1));
        2: begin
          m_tready = pat[pat_i % 8];
          pat_i++;
        end
        3:       m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = 1'b1;
      endcase
    end
  end

  initial begin
    obeat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && axis_aresetn) begin
        if (m_tvalid && m_tready) begin
          beats_out++;
          last_beat_cyc = cyc;
          if (expq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat: got 0x%0h with no beat outstanding", m_tdata);
          end else begin
            e = expq.pop_front();
            check("out_beat", 64'({m_tdata, m_tstrb, m_tlast}), 64'({e.dat, e.strb, e.last}));
          end
        end
        if (m_tvalid && !m_tready) check("s_tready_when_full", 64'(s_tready), 64'(0));
        check("s_tready_onehot0", 64'($onehot0(s_tready)), 64'(1));
        if (pkt_done) pkt_cnt++;
`ifdef ARB_PKT_LIMIT_EN
        if (pkt_trunc) trunc_cnt++;
`endif
      end
    end
  end

  initial begin
    int   k, w;
    logic acc;
    pat          = 8'b01101001;
    pat_i        = 0;
    sink_mode    = 1;
    m_tready     = 1'b1;
    mon_en       = 1'b0;
    bubble_en    = 1'b0;
    axis_aresetn = 1'b0;
    enable       = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      tv[s] = 1'b0;
      tl[s] = 1'b0;
      td[s] = '0;
      ts[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    axis_aresetn = 1'b1;
    mdl_last     = NSRC - 1;

    // Single 4-beat packet: latency, span and grant.
    gen_pkt(0, 4, 28'h11, 1'b0);
    run_phase(1, 0, 1'b1, 5);

    // Two sources together: no interleave, one idle cycle between packets.
    gen_pkt(0, 3, 28'hA0, 1'b0);
    gen_pkt(1, 3, 28'hB0, 1'b0);
    run_phase(1, 0, 1'b0, 8);
    gen_pkt(0, 2, 28'hC0, 1'b0);
    gen_pkt(1, 2, 28'hD0, 1'b0);
    run_phase(1, 0, 1'b0, -1);

    // Stuttering sink on an 8-beat packet.
    gen_pkt(1, 8, 28'h30, 1'b0);
    pat_i = 0;
    run_phase(2, 0, 1'b0, -1);

    // enable low: no grant; enable dropped mid-packet: packet completes.
    enable = 1'b0;
    tv[0]  = 1'b1;
    td[0]  = 32'h40;
    tl[0]  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("disabled_s_tready", 64'(s_tready), 64'(0));
      check("disabled_busy", 64'(busy), 64'(0));
    end
    @(posedge clk);
    #1;
    tv[0] = 1'b0;
    gen_pkt(0, 5, 28'h50, 1'b0);
    run_phase(3, 2, 1'b0, -1);

    // Reset in the middle of a 6-beat packet.
    mon_en = 1'b0;
    k      = 0;
    w      = 0;
    tv[0]  = 1'b1;
    td[0]  = 32'h70;
    ts[0]  = 4'hF;
    tl[0]  = 1'b0;
    while (k < 2 && w < 20) begin
      @(negedge clk);
      acc = s_tready[0];
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        td[0] = 32'h70 + k;
      end
      w++;
    end
    check("pre_reset_beats", 64'(k), 64'(2));
    axis_aresetn = 1'b0;
    @(posedge clk);
    #1;
    tv[0] = 1'b0;
    @(negedge clk);
    check_reset_state("midpkt_reset");
    @(posedge clk);
    #1;
    axis_aresetn = 1'b1;
    mdl_last     = NSRC - 1;
    gen_pkt(1, 2, 28'h81, 1'b0);
    gen_pkt(2, 2, 28'h82, 1'b0);
    gen_pkt(0, 2, 28'h80, 1'b0);
    run_phase(1, 0, 1'b0, -1);

    // Six beats: whole packet by default, 4+2 with the beat cap.
    gen_pkt(0, 6, 28'h60, 1'b0);
    run_phase(1, 0, 1'b0, -1);

    bubble_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < NSRC; s++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) gen_pkt(s, $urandom_range(1, 8), 28'h0, 1'b1);
      end
      run_phase($urandom_range(0, 3), 0, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
